// File: rtl/ps2_keycode_decoder_pkg.sv
// Shared types, scan-code constants and the scan-to-HID key map for the
// PS/2 keycode decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_E0,
    DEC_F0,
    DEC_E0_F0
  } dec_state_t;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;

  // Returns 8'h00 for anything outside the game's key set.
  function automatic logic [7:0] map_scan(input logic ext, input logic [7:0] scan);
    map_scan = 8'h00;
    if (!ext) begin
      case (scan)
        8'h1D:   map_scan = KEY_W;
        8'h1B:   map_scan = KEY_S;
        8'h1C:   map_scan = KEY_A;
        8'h23:   map_scan = KEY_D;
        8'h5A:   map_scan = KEY_ENTER;
        default: map_scan = 8'h00;
      endcase
    end else begin
      case (scan)
        8'h75:   map_scan = KEY_UP;
        8'h72:   map_scan = KEY_DOWN;
        8'h6B:   map_scan = KEY_LEFT;
        8'h74:   map_scan = KEY_RIGHT;
        default: map_scan = 8'h00;
      endcase
    end
  endfunction

endpackage

// File: rtl/ps2_keycode_decoder_if.sv
// PS/2 pin inputs and the keycode bus produced for the game logic.
interface ps2_keycode_decoder_if;
  logic       PS2_Clk;
  logic       PS2_Data;
  logic [7:0] keycode;
  logic       key_event;
  logic       frame_error;

  modport master (input PS2_Clk, PS2_Data, output keycode, key_event, frame_error);
  modport slave  (output PS2_Clk, PS2_Data, input keycode, key_event, frame_error);
endinterface

// File: rtl/ps2_keycode_decoder_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit framing
// with odd-parity/stop checks and a mid-frame idle timeout.
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_error
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1, clk_s2, clk_prev;
  logic          data_s1, data_s2;
  logic          fall_p0;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity;
  logic [TW-1:0] idle_cnt;

  // Clock sync resets high so leaving reset never looks like a falling edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
    end
  end

  always_ff @(posedge Clk) begin
    data_s1 <= ps2_data;
    data_s2 <= data_s1;
  end

  assign fall_p0 = clk_prev & ~clk_s2;
  assign rx_byte = shift;

  always_ff @(posedge Clk) begin
    if (fall_p0) begin
      if (bit_cnt >= 4'd1 && bit_cnt <= 4'd8)
        shift <= {data_s2, shift[7:1]};
      else if (bit_cnt == 4'd9)
        parity <= data_s2;
    end
  end

  // ---- stage p1: frame result and timeout ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bit_cnt     <= 4'd0;
      idle_cnt    <= '0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (fall_p0) begin
        idle_cnt <= '0;
        case (bit_cnt)
          4'd0: begin
            if (data_s2) frame_error <= 1'b1;
            else         bit_cnt     <= 4'd1;
          end
          4'd10: begin
            bit_cnt <= 4'd0;
            if (data_s2 && (^{shift, parity})) byte_valid  <= 1'b1;
            else                               frame_error <= 1'b1;
          end
          default: bit_cnt <= bit_cnt + 4'd1;
        endcase
      end else if (bit_cnt == 4'd0) begin
        idle_cnt <= '0;
      end else if (idle_cnt == TW'(TIMEOUT_CYCLES)) begin
        bit_cnt     <= 4'd0;
        idle_cnt    <= '0;
        frame_error <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keycode_decoder.sv
// Scan-code set 2 make/break decoder driving the held-key keycode bus.
module ps2_keycode_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                   Clk,
  input  logic                   Reset,
  ps2_keycode_decoder_if.master  bus
);
  logic [7:0] rx_byte;
  logic       byte_valid_p1;
  logic       rx_frame_error;

  dec_state_t state, state_n;
  logic [7:0] keycode_p2, keycode_n;
  logic       vld_p2, event_n;
  logic       ext, brk, act;
  logic [7:0] mapped;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .Clk         (Clk),
    .Reset       (Reset),
    .ps2_clk     (bus.PS2_Clk),
    .ps2_data    (bus.PS2_Data),
    .rx_byte     (rx_byte),
    .byte_valid  (byte_valid_p1),
    .frame_error (rx_frame_error)
  );

  // ---- stage p2: decoder state and keycode register ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= DEC_IDLE;
      keycode_p2 <= 8'h00;
      vld_p2     <= 1'b0;
    end else begin
      state      <= state_n;
      keycode_p2 <= keycode_n;
      vld_p2     <= event_n;
    end
  end

  always_comb begin
    state_n   = state;
    keycode_n = keycode_p2;
    event_n   = 1'b0;
    ext       = 1'b0;
    brk       = 1'b0;
    act       = 1'b0;
    if (byte_valid_p1) begin
      case (state)
        DEC_IDLE: begin
          if (rx_byte == SC_E0)      state_n = DEC_E0;
          else if (rx_byte == SC_F0) state_n = DEC_F0;
          else                       act     = 1'b1;
        end
        DEC_E0: begin
          if (rx_byte == SC_F0) state_n = DEC_E0_F0;
          else if (rx_byte != SC_E0) begin
            act     = 1'b1;
            ext     = 1'b1;
            state_n = DEC_IDLE;
          end
        end
        DEC_F0: begin
          act     = 1'b1;
          brk     = 1'b1;
          state_n = DEC_IDLE;
        end
        DEC_E0_F0: begin
          act     = 1'b1;
          brk     = 1'b1;
          ext     = 1'b1;
          state_n = DEC_IDLE;
        end
        default: state_n = DEC_IDLE;
      endcase
    end
    mapped = map_scan(ext, rx_byte);
    // Last press wins; only releasing the held key clears the bus.
    if (act && mapped != 8'h00) begin
      if (!brk && mapped != keycode_p2) begin
        keycode_n = mapped;
        event_n   = 1'b1;
      end else if (brk && mapped == keycode_p2) begin
        keycode_n = 8'h00;
        event_n   = 1'b1;
      end
    end
  end

  assign bus.keycode     = keycode_p2;
  assign bus.key_event   = vld_p2;
  assign bus.frame_error = rx_frame_error;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Scoreboard bench for ps2_keycode_decoder: drives PS/2 frames on the pins and
// compares every key_event against queued expected keycodes.
module tb_ps2_keycode_decoder;
  localparam int TO = 300;
  localparam int H  = 10;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   ferr_cnt    = 0;
  logic [7:0] exp_q[$];

  ps2_keycode_decoder_if bus();

  ps2_keycode_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every key_event must match the next queued keycode.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.key_event) begin
        if (exp_q.size() == 0) check_val("spurious_event", 32'(bus.keycode), 32'hFFFF);
        else check_val("keycode_evt", 32'(bus.keycode), 32'(exp_q.pop_front()));
      end
      if (bus.frame_error) ferr_cnt++;
    end
  end

  task automatic ps2_bit(input logic b);
    bus.PS2_Data = b;
    repeat (H) @(posedge clk);
    #1 bus.PS2_Clk = 1'b0;
    repeat (H) @(posedge clk);
    #1 bus.PS2_Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(bad_par ? (^b) : ~(^b));
    ps2_bit(1'b1);
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic drained(input string tag);
    check_val(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    int ferr0;
    bus.PS2_Clk  = 1'b1;
    bus.PS2_Data = 1'b1;
    rst = 1'b1;
    #1;
    check_val("rst_keycode", 32'(bus.keycode), 32'h00);
    check_val("rst_event",   32'(bus.key_event), 32'h0);
    check_val("rst_ferr",    32'(bus.frame_error), 32'h0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Enter press and release
    exp_q.push_back(8'h28); send_frame(8'h5A, 1'b0);
    drained("enter_make");
    check_val("enter_hold", 32'(bus.keycode), 32'h28);
    exp_q.push_back(8'h00); send_frame(8'hF0, 1'b0); send_frame(8'h5A, 1'b0);
    drained("enter_break");

    // Extended Up with typematic repeats
    exp_q.push_back(8'h52); send_frame(8'hE0, 1'b0); send_frame(8'h75, 1'b0);
    drained("up_make");
    for (int i = 0; i < 3; i++) begin
      send_frame(8'hE0, 1'b0); send_frame(8'h75, 1'b0);
    end
    check_val("up_typematic", 32'(bus.keycode), 32'h52);
    exp_q.push_back(8'h00);
    send_frame(8'hE0, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h75, 1'b0);
    drained("up_break");

    // Last press wins; releasing a non-held key is ignored
    exp_q.push_back(8'h1A); send_frame(8'h1D, 1'b0);
    exp_q.push_back(8'h16); send_frame(8'h1B, 1'b0);
    send_frame(8'hF0, 1'b0); send_frame(8'h1D, 1'b0);
    check_val("w_release_ignored", 32'(bus.keycode), 32'h16);
    drained("ws_seq");
    exp_q.push_back(8'h00); send_frame(8'hF0, 1'b0); send_frame(8'h1B, 1'b0);
    drained("s_break");

    // Bad parity frame is dropped
    ferr0 = ferr_cnt;
    send_frame(8'h1C, 1'b1);
    check_val("parity_ferr", 32'(ferr_cnt), 32'(ferr0 + 1));
    check_val("parity_keycode", 32'(bus.keycode), 32'h00);

    // Start bit sampled high is rejected at once
    ferr0 = ferr_cnt;
    ps2_bit(1'b1);
    repeat (10) @(posedge clk);
    check_val("start1_ferr", 32'(ferr_cnt), 32'(ferr0 + 1));
    exp_q.push_back(8'h04); send_frame(8'h1C, 1'b0);
    drained("a_make");

    // Mid-frame timeout
    ferr0 = ferr_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'(i));
    repeat (TO - 10) @(posedge clk);
    check_val("timeout_early", 32'(ferr_cnt), 32'(ferr0));
    for (int i = 0; i < 60 && ferr_cnt == ferr0; i++) @(posedge clk);
    check_val("timeout_ferr", 32'(ferr_cnt), 32'(ferr0 + 1));
    repeat (5) @(posedge clk);
    #1;
    exp_q.push_back(8'h07); send_frame(8'h23, 1'b0);
    drained("d_make");

    // Async reset after an E0 prefix clears keycode and the prefix
    send_frame(8'hE0, 1'b0);
    #3 rst = 1'b1;
    #1;
    check_val("reset_keycode", 32'(bus.keycode), 32'h00);
    check_val("reset_event",   32'(bus.key_event), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_frame(8'h75, 1'b0);
    check_val("post_reset_75", 32'(bus.keycode), 32'h00);
    drained("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_keycode_decoder.md
# ps2_keycode_decoder

Converts the PS/2 keyboard serial stream into the 8-bit HID-style `keycode` bus consumed by the game state machine and the player controllers. It is the producer end of the `keycode` interface. It receives PS/2 frames, decodes scan-code set 2 make/break sequences including the E0 prefix, and holds the keycode of the currently held mapped key. The bus reads 8'h00 when no mapped key is held.

## Interface
- `TIMEOUT_CYCLES`, default 50000: number of idle `Clk` cycles mid-frame after which a partial frame is discarded.
- `Clk`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `PS2_Clk`  in  1  raw PS/2 clock from the pin; asynchronous to `Clk`.
- `PS2_Data`  in  1  raw PS/2 data from the pin.
- `keycode`  out  8  HID code of the held mapped key; 8'h00 when none is held.
- `key_event`  out  1  one-cycle pulse whenever `keycode` changes value.
- `frame_error`  out  1  one-cycle pulse when a frame is dropped (bad start, parity, stop, or timeout).

## Operation
- **Reset.** `keycode`=8'h00, `key_event`=0, `frame_error`=0. The receiver and the decoder FSM return to idle.
- **Synchronisation.** `PS2_Clk` and `PS2_Data` each pass through 2 flops. A falling edge is the synchronised clock low while its previous sample was high.
- **Framing.** One frame is 11 bits sampled on falling edges: start=0, D0..D7 (LSB first), odd parity, stop=1.
  - A valid frame produces a one-cycle `byte_valid` carrying the data byte.
  - An invalid frame produces `frame_error` and is discarded; the receiver returns to waiting for a start bit.
  - A start bit sampled as 1 is rejected immediately: `frame_error` pulses and the bit counter stays at 0.
- **Timeout.** If the bit counter is nonzero and no falling edge arrives for `TIMEOUT_CYCLES` cycles, the counter clears and `frame_error` pulses.
- **Decoder FSM states:** `DEC_IDLE`, `DEC_E0`, `DEC_F0`, `DEC_E0_F0`. On each `byte_valid`:
  - `DEC_IDLE`: E0 → `DEC_E0`; F0 → `DEC_F0`; any other byte → make(byte, ext=0), stay in `DEC_IDLE`.
  - `DEC_E0`: F0 → `DEC_E0_F0`; E0 → stay in `DEC_E0`; any other byte → make(byte, ext=1), then `DEC_IDLE`.
  - `DEC_F0`: any byte → break(byte, ext=0), then `DEC_IDLE`.
  - `DEC_E0_F0`: any byte → break(byte, ext=1), then `DEC_IDLE`.
- **Key map** (ext, scan → keycode):
  - Non-extended: W 1D→1A, S 1B→16, A 1C→04, D 23→07, Enter 5A→28.
  - Extended: Up 75→52, Down 72→51, Left 6B→50, Right 74→4F.
  - An unmapped make or break has no effect. This covers E1 sequences and the keyboard responses AA, FA, EE.
- **make.** If the code is mapped and differs from `keycode`, load it and pulse `key_event`. Typematic repeats of the held key produce no pulse.
- **break.** If the mapped code equals `keycode`, load 8'h00 and pulse `key_event`. Releasing a key that is not the current one is ignored.
- **Priority.** The last pressed mapped key wins; there is no multi-key tracking.

## Timing
- Let cycle T be the cycle in which the stop-bit falling edge is detected after synchronisation. Then:
  - `byte_valid` is asserted at T+1.
  - `keycode` and `key_event` update at T+2.
  - `frame_error` is asserted at T+1.
- Total latency from the pin edge to `keycode` is 4 `Clk` cycles: 2 synchroniser cycles plus 2.
- `keycode` is registered and stable between events. `key_event` is high for exactly 1 cycle.
- A `byte_valid` arriving in the same cycle as a timeout cannot occur: a completed frame clears the timeout counter.
- Reset asserted mid-frame discards the partial frame and any pending E0/F0 prefix. Outputs go to their reset values immediately, asynchronously.
- The timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`. It saturates and never wraps.

## Structure
- Package `ps2_pkg` holds:
  - `dec_state_t` enum;
  - scan-code constants `SC_E0`=8'hE0 and `SC_F0`=8'hF0;
  - the keycode constants `KEY_W`, `KEY_S`, `KEY_A`, `KEY_D`, `KEY_ENTER`, `KEY_UP`, `KEY_DOWN`, `KEY_LEFT`, `KEY_RIGHT`;
  - the map function `map_scan(ext, scan)`, which returns 8'h00 for an unmapped code.
- Sub-module `ps2_rx` contains the synchroniser, edge detect, 11-bit shift register, parity/stop check and timeout. Its outputs are `rx_byte[7:0]`, `byte_valid` and `frame_error`.
- The top level holds the decoder FSM and the `keycode` register.

## Test plan
- Frame 5A → `keycode`=8'h28 with a single `key_event` pulse. Then frames F0,5A → `keycode`=8'h00 with a second pulse.
- Frames E0,75 → 8'h52. Repeat E0,75 three times (typematic) → no further `key_event`. Then E0,F0,75 → 8'h00.
- Frame 1D → 8'h1A. Frame 1B → 8'h16. Frames F0,1D → `keycode` stays 8'h16 with no pulse.
- Frame 1C sent with wrong parity → `frame_error` pulses once and `keycode` stays 8'h00. The next valid frame 1C → 8'h04.
- Send 5 bits, then idle for `TIMEOUT_CYCLES`+1 cycles → `frame_error` pulses. A subsequent full frame 23 → 8'h07.
- Assert `Reset` after byte E0 while holding 8'h07 → `keycode`=8'h00 immediately. Then frame 75 decodes as unmapped, non-extended: `keycode` stays 8'h00.
